irq_timer: RTL and testbench
============================

Name: irq_timer

Overview:
- Memory-mapped programmable countdown timer on the CPU bridge.
- Drives one HWInt line into CP0, so it is the interrupt-source end of the CP0 HWInt/Req path.
- Software programs it with sw/lw over a word-addressed register window.
- On terminal count it asserts IRQ, either held (mode 0) or as a periodic one-cycle pulse (mode 1).

Parameters:
- CNT_W, 32, width of PRESET and COUNT registers and of the data bus.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- Addr  input  2  word offset; byte address bits [3:2].
- WE  input  1  bus write enable, sampled on clk rising edge.
- Din  input  CNT_W  write data.
- Dout  output  CNT_W  read data, combinational from Addr.
- IRQ  output  1  interrupt request to CP0 HWInt bit.

Behaviour:
- Register map (Addr):
  - 0 CTRL: [0] En, [2:1] Mode, [3] IM; bits above 3 read 0.
  - 1 PRESET.
  - 2 COUNT, read-only; writes ignored.
  - 3 reserved; reads 0, writes ignored.
- Reset values while reset=0: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0, Dout reflects the cleared registers.
- Writes:
  - WE=1, Addr=0: CTRL[3:0] <= Din[3:0], and irq_flag cleared.
  - WE=1, Addr=1: PRESET <= Din, and irq_flag cleared.
- IRQ = irq_flag & CTRL.IM, purely combinational. Clearing IM masks IRQ but does not clear irq_flag.
- Mode encoding: Mode=01 is auto-reload; 00, 10 and 11 all behave as mode 0 (one-shot).
- FSM, evaluated each rising edge:
  - IDLE: if En=1, go to LOAD and clear irq_flag; otherwise stay (irq_flag held).
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if En=0, go to IDLE with COUNT frozen. Else if COUNT>1, COUNT <= COUNT-1. Else (COUNT is 0 or 1) COUNT <= 0 and go to INT.
  - INT: irq_flag <= 1; go to IDLE. In mode 0, CTRL.En <= 0 at this edge.
- Timing:
  - IRQ rises exactly P+3 rising edges after the edge that wrote En=1, for PRESET=P≥1. For P=0 it rises after 4 edges, same as P=1.
  - Mode 1: IRQ is high for exactly one cycle, the IDLE cycle before reload. Period is P+3 cycles.
  - Mode 0: IRQ stays high until a CTRL or PRESET write, or reset.
- Simultaneous events:
  - A bus CTRL write wins over the FSM's En clear in INT. irq_flag set by INT still applies unless the same edge writes CTRL or PRESET, in which case the clear wins.
  - PRESET written during CNT takes effect only at the next LOAD.
  - Clearing En during CNT pauses the timer. Re-enabling restarts from LOAD, not from the frozen COUNT.
- reset=0 mid-count: everything returns to reset values asynchronously. Counting resumes only after reset=1 and a new En=1 write.
- COUNT arithmetic is unsigned CNT_W-bit with no wrap below 0. PRESET=32'hFFFFFFFF is legal.

Test Plan:
- Reset: drive reset=0 mid-count with En=1, PRESET=100 → IRQ=0 and Dout=0 for Addr 0/1/2 immediately, without waiting for a clock edge.
- Mode 0 one-shot: PRESET=5, then CTRL=4'b1001 → IRQ rises exactly 8 edges after the CTRL write. CTRL reads 4'b1000 (En cleared), COUNT=0. IRQ stays high 20+ cycles, then drops on the edge of a CTRL write.
- Mode 1 periodic: PRESET=3, CTRL=4'b1011 → IRQ is a 1-cycle pulse every 6 cycles for 5 periods. COUNT reads 3,2,1 during each CNT phase.
- Mask and pause:
  - IM=0 with PRESET=2 in mode 0 → IRQ stays 0 after terminal count. Writing CTRL=4'b1000 then clears the flag, so IRQ stays 0.
  - En cleared while COUNT=7 → COUNT holds 7.
- Boundaries:
  - PRESET=0 and PRESET=1 → IRQ rises after 4 edges in both cases.
  - A write to Addr=2 leaves COUNT unchanged; Addr=3 reads 0.
  - A CTRL write on the same edge as the INT state → the written En value wins and irq_flag stays 0.

Source files
------------

// File: rtl/irq_timer.sv
// Programmable countdown timer that raises an interrupt request on terminal count,
// either as a held level (one-shot) or a single-cycle pulse per period (auto-reload).
module irq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic [CNT_W-1:0] Din,
  output logic [CNT_W-1:0] Dout,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             en_s;
  logic             auto_reload_s;

  assign en_s          = ctrl_q[0];
  assign auto_reload_s = (ctrl_q[2:1] == 2'b01);

  // Next-state: timer sequencing first, then bus writes override it on the same edge.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: begin
        if (en_s) begin
          state_d = S_LOAD;
          flag_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_s) begin
          state_d = S_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d = {CNT_W{1'b0}};
          state_d = S_INT;
        end
      end
      S_INT: begin
        flag_d  = 1'b1;
        state_d = S_IDLE;
        if (!auto_reload_s) begin
          ctrl_d[0] = 1'b0;
        end else begin
          ctrl_d[0] = ctrl_q[0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (WE) begin
      case (Addr)
        2'd0: begin
          ctrl_d = Din[3:0];
          flag_d = 1'b0;
        end
        2'd1: begin
          preset_d = Din;
          flag_d   = 1'b0;
        end
        default: ;
      endcase
    end else begin
      flag_d = flag_d;
    end
  end

  // Timer state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'b0000;
      preset_q <= {CNT_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Read mux; COUNT is visible but not writable, the reserved word reads zero.
  always_comb begin
    case (Addr)
      2'd0:    Dout = {{(CNT_W-4){1'b0}}, ctrl_q};
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = {CNT_W{1'b0}};
    endcase
  end

  assign IRQ = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_irq_timer.sv
// Self-checking bench for irq_timer: register-access table, corner-case sequences
// and randomized programs checked against a cycle-offset timing model.
module tb_irq_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic        IRQ;

  int n_vec = 0;
  int n_err = 0;

  irq_timer #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    Addr = a; Din = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Returns the number of edges until IRQ is first seen high, 0 on timeout.
  task automatic edges_to_irq(input int limit, output int first);
    first = 0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (IRQ && first == 0) first = k;
    end
  endtask

  vec_t tbl[10];

  initial begin
    int first, p, pe, n, m, ec;
    logic [1:0] md;
    logic im, ef, reload;
    logic [31:0] hist, expv;

    // Reset state
    #1;
    check("reset_irq", 32'(IRQ), 32'd0);
    check("reset_ctrl", Dout, 32'd0);
    #2 reset = 1'b1;

    // Register access table, timer disabled throughout
    tbl[0] = '{1'b1, 2'd1, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[1] = '{1'b0, 2'd1, 32'h0000_0000, 32'h1234_5678, 1'b0};
    tbl[2] = '{1'b1, 2'd0, 32'hFFFF_FFF6, 32'h0000_0006, 1'b0};
    tbl[3] = '{1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[4] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[5] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0006, 1'b0};
    tbl[7] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[8] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tbl[9] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      WE = tbl[i].we; Addr = tbl[i].addr; Din = tbl[i].din;
      tick();
      WE = 1'b0;
      check($sformatf("table_dout[%0d]", i), Dout, tbl[i].exp_dout);
      check($sformatf("table_irq[%0d]", i), 32'(IRQ), 32'(tbl[i].exp_irq));
    end

    // Asynchronous reset mid-count
    do_reset();
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'h9);
    repeat (10) tick();
    Addr = 2'd2; #1;
    check("midcount_count", Dout, 32'd92);
    reset = 1'b0; #1;
    check("async_irq", 32'(IRQ), 32'd0);
    check("async_count", Dout, 32'd0);
    Addr = 2'd0; #1; check("async_ctrl", Dout, 32'd0);
    Addr = 2'd1; #1; check("async_preset", Dout, 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    Addr = 2'd2; #1;
    check("post_reset_idle", Dout, 32'd0);

    // Mode 0 one-shot, held level until a CTRL write
    do_reset();
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    edges_to_irq(20, first);
    check("oneshot_latency", 32'(first), 32'd8);
    Addr = 2'd0; #1; check("oneshot_ctrl", Dout, 32'h8);
    Addr = 2'd2; #1; check("oneshot_count", Dout, 32'd0);
    first = 0;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (IRQ) first++;
    end
    check("oneshot_hold", 32'(first), 32'd22);
    bus_write(2'd0, 32'h8);
    check("oneshot_clear", 32'(IRQ), 32'd0);

    // Mode 1 periodic, P=3 gives a pulse every 6 edges
    do_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    Addr = 2'd2;
    hist = 32'd0; expv = 32'd0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      hist[k] = IRQ;
      expv[k] = (k % 6 == 0);
      if (k >= 2 && k <= 4) check("periodic_count", Dout, 32'(5 - k));
    end
    check("periodic_irq", hist, expv);

    // Masked terminal count, then CTRL write clears the hidden flag
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    repeat (10) tick();
    check("masked_irq", 32'(IRQ), 32'd0);
    Addr = 2'd0; #1; check("masked_ctrl", Dout, 32'h0);
    bus_write(2'd0, 32'h8);
    check("masked_unmask", 32'(IRQ), 32'd0);

    // Pause at COUNT=7, then re-enable restarts from PRESET
    do_reset();
    bus_write(2'd1, 32'd20);
    bus_write(2'd0, 32'h1);
    repeat (14) tick();
    bus_write(2'd0, 32'h0);
    repeat (5) tick();
    Addr = 2'd2; #1;
    check("pause_count", Dout, 32'd7);
    bus_write(2'd0, 32'h1);
    Addr = 2'd2;
    tick(); tick();
    check("restart_count", Dout, 32'd20);

    // PRESET 0 and 1 share the same latency
    for (int i = 0; i < 2; i++) begin
      do_reset();
      bus_write(2'd1, 32'(i));
      bus_write(2'd0, 32'h9);
      edges_to_irq(10, first);
      check($sformatf("latency_p%0d", i), 32'(first), 32'd4);
    end

    // CTRL write on the INT edge wins over the En clear and the flag set
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    repeat (4) tick();
    bus_write(2'd0, 32'h9);
    check("int_collide_irq", 32'(IRQ), 32'd0);
    check("int_collide_ctrl", Dout, 32'h9);
    edges_to_irq(10, first);
    check("int_collide_rerun", 32'(first), 32'd5);

    // Full-scale PRESET
    do_reset();
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'h1);
    Addr = 2'd2;
    tick(); tick();
    check("max_load", Dout, 32'hFFFF_FFFF);
    tick();
    check("max_dec", Dout, 32'hFFFF_FFFE);

    // Randomized programs against the edge-offset timing model
    for (int t = 0; t < 12; t++) begin
      p  = $urandom_range(0, 12);
      md = 2'($urandom_range(0, 3));
      im = 1'($urandom_range(0, 1));
      reload = (md == 2'b01);
      pe = (p == 0) ? 1 : p;
      n  = pe + 3;
      do_reset();
      bus_write(2'd1, 32'(p));
      bus_write(2'd0, {28'd0, im, md, 1'b1});
      Addr = 2'd2;
      for (int k = 1; k <= 3 * n; k++) begin
        tick();
        if (reload) begin
          m  = (k - 1) % n;
          ef = (m == n - 1);
          ec = (p != 0 && m >= 1 && m <= pe) ? p - (m - 1) : 0;
        end else begin
          ef = (k >= n);
          ec = (p != 0 && k >= 2 && k <= pe + 1) ? p - (k - 2) : 0;
        end
        check("rnd_irq", 32'(IRQ), 32'(ef & im));
        check("rnd_count", Dout, 32'(ec));
      end
      Addr = 2'd0; #1;
      check("rnd_ctrl", Dout, {28'd0, im, md, reload});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
